// File: rtl/histogram_engine_param.sv
// histogram_engine_param
//   Bins a pixel stream into 2**BIN_BITS saturating counters for one armed
//   frame, then copies the bins into a readout RAM while clearing the working
//   RAM. The processor arms the block with start and reads bins through
//   rd_addr/rd_data once done has pulsed.
//
// Ports
//   clk           clock
//   rst           synchronous reset, active-high; aborts and reruns INIT
//   start         arm request, sampled only in IDLE
//   in_pixel      pixel sample, bin = in_pixel[PIX_W-1 -: BIN_BITS]
//   in_valid      in_pixel qualifier
//   end_of_frame  last pixel of a frame, only meaningful with in_valid
//   rd_addr       readout bin index
//   rd_data       readout[rd_addr], one cycle latency
//   busy          high in every state except IDLE
//   done          one-cycle pulse when the readout RAM holds a new histogram
//
// Build option
//   HIST_CUMULATIVE_EN : readout[i] holds the saturating running sum of
//                        bins 0..i instead of the bin count.
module histogram_engine_param #(
  parameter int PIX_W    = 8,
  parameter int BIN_BITS = 8,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [PIX_W-1:0]    in_pixel,
  input  logic                in_valid,
  input  logic                end_of_frame,
  input  logic [BIN_BITS-1:0] rd_addr,
  output logic [CNT_W-1:0]    rd_data,
  output logic                busy,
  output logic                done
);

  localparam int NBINS = 1 << BIN_BITS;
  localparam logic [BIN_BITS:0] ZERO_C  = {(BIN_BITS+1){1'b0}};
  localparam logic [BIN_BITS:0] ONE_C   = (BIN_BITS+1)'(1);
  localparam logic [BIN_BITS:0] LAST_C  = (BIN_BITS+1)'(NBINS - 1);
  localparam logic [BIN_BITS:0] NBINS_C = (BIN_BITS+1)'(NBINS);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ARMED, S_ACCUM, S_DRAIN, S_FLUSH, S_DONE
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) sat_inc = v;
    else              sat_inc = v + CNT_W'(1);
  endfunction

`ifdef HIST_CUMULATIVE_EN
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[CNT_W]) sat_add = CNT_MAX;
    else          sat_add = s[CNT_W-1:0];
  endfunction
`endif

  logic [CNT_W-1:0]    work_mem [NBINS];
  logic [CNT_W-1:0]    rd_mem   [NBINS];

  state_t              state_r, state_s;
  logic [BIN_BITS:0]   cnt_r;
  logic [BIN_BITS-1:0] cnt_idx_s, pix_bin_s;
  logic                busy_s, done_s, busy_r, done_r;
  logic [CNT_W-1:0]    rd_data_r;

  // RMW stage0 (read issued) and last-write registers used for forwarding
  logic                s0_vld_r;
  logic [BIN_BITS-1:0] s0_bin_r;
  logic [CNT_W-1:0]    s0_data_r;
  logic                wr_vld_r;
  logic [BIN_BITS-1:0] wr_bin_r;
  logic [CNT_W-1:0]    wr_data_r;
  logic [CNT_W-1:0]    base_s, inc_s;

  // FLUSH pipeline: read+clear working bin, then write readout one cycle later
  logic                flush_rd_s, flush_vld_r;
  logic [BIN_BITS-1:0] flush_idx_r;
  logic [CNT_W-1:0]    flush_data_r, ro_val_s;

  assign cnt_idx_s = cnt_r[BIN_BITS-1:0];
  assign pix_bin_s = in_pixel[PIX_W-1 -: BIN_BITS];
  assign flush_rd_s = (state_r == S_FLUSH) && (cnt_r != NBINS_C);
  assign rd_data = rd_data_r;
  assign busy    = busy_r;
  assign done    = done_r;

  // The memory read at stage0 misses only the write landing on the same
  // edge, so one level of forwarding from the last write covers both
  // back-to-back and one-apart pixels to the same bin.
  assign base_s = (wr_vld_r && (wr_bin_r == s0_bin_r)) ? wr_data_r : s0_data_r;
  assign inc_s  = sat_inc(base_s);

`ifdef HIST_CUMULATIVE_EN
  logic [CNT_W-1:0] acc_r;
  assign ro_val_s = sat_add(acc_r, flush_data_r);

  // Running sum across the FLUSH pass, cleared outside FLUSH
  always_ff @(posedge clk) begin
    if (rst)                     acc_r <= {CNT_W{1'b0}};
    else if (flush_vld_r)        acc_r <= ro_val_s;
    else if (state_r != S_FLUSH) acc_r <= {CNT_W{1'b0}};
    else                         acc_r <= acc_r;
  end
`else
  assign ro_val_s = flush_data_r;
`endif

  // Next-state and registered-output decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_INIT:  if (cnt_r == LAST_C) state_s = S_IDLE;  else state_s = S_INIT;
      S_IDLE:  if (start) state_s = S_ARMED; else state_s = S_IDLE;
      S_ARMED: if (in_valid && end_of_frame) state_s = S_ACCUM; else state_s = S_ARMED;
      S_ACCUM: if (in_valid && end_of_frame) state_s = S_DRAIN; else state_s = S_ACCUM;
      S_DRAIN: if (cnt_r == ONE_C) state_s = S_FLUSH; else state_s = S_DRAIN;
      S_FLUSH: if (cnt_r == NBINS_C) state_s = S_DONE; else state_s = S_FLUSH;
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_INIT;
    endcase
    busy_s = (state_s != S_IDLE);
    done_s = (state_s == S_DONE);
  end

  // State, per-state cycle counter, pipeline control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_INIT;
      cnt_r       <= ZERO_C;
      busy_r      <= 1'b1;
      done_r      <= 1'b0;
      rd_data_r   <= {CNT_W{1'b0}};
      s0_vld_r    <= 1'b0;
      s0_bin_r    <= {BIN_BITS{1'b0}};
      wr_vld_r    <= 1'b0;
      wr_bin_r    <= {BIN_BITS{1'b0}};
      wr_data_r   <= {CNT_W{1'b0}};
      flush_vld_r <= 1'b0;
      flush_idx_r <= {BIN_BITS{1'b0}};
    end else begin
      state_r     <= state_s;
      cnt_r       <= (state_s != state_r) ? ZERO_C : cnt_r + ONE_C;
      busy_r      <= busy_s;
      done_r      <= done_s;
      rd_data_r   <= rd_mem[rd_addr];
      s0_vld_r    <= (state_r == S_ACCUM) && in_valid;
      s0_bin_r    <= pix_bin_s;
      wr_vld_r    <= s0_vld_r;
      wr_bin_r    <= s0_bin_r;
      wr_data_r   <= inc_s;
      flush_vld_r <= flush_rd_s;
      flush_idx_r <= cnt_idx_s;
    end
  end

  // Working and readout RAM ports; INIT and FLUSH own the RAMs exclusively
  always_ff @(posedge clk) begin
    s0_data_r    <= work_mem[pix_bin_s];
    flush_data_r <= work_mem[cnt_idx_s];
    if ((state_r == S_INIT) || flush_rd_s) work_mem[cnt_idx_s] <= {CNT_W{1'b0}};
    else if (s0_vld_r)                     work_mem[s0_bin_r]  <= inc_s;
    if (state_r == S_INIT)                 rd_mem[cnt_idx_s]   <= {CNT_W{1'b0}};
    else if (flush_vld_r)                  rd_mem[flush_idx_r] <= ro_val_s;
  end

endmodule
